team_06_env_detector: RTL
=========================

TEAM_06_ENV_DETECTOR -- requirements
Module: team_06_env_detector

Interface
REQ-001 SHALL have parameter ATTACK_SHIFT, default 2, attack smoothing shift (1..6).
REQ-002 SHALL have parameter DECAY_SHIFT, default 5, decay smoothing shift (1..8).
REQ-003 SHALL have parameter HYST, default 4, envelope hysteresis for peak/trough detection, in env_out LSBs.
REQ-004 SHALL have port clk, input, 1, system clock.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port en, input, 1, block enable.
REQ-007 SHALL have port sample_valid, input, 1, one-cycle strobe marking a new audio_in sample.
REQ-008 SHALL have port audio_in, input, 8, offset-binary audio sample; 128 is silence.
REQ-009 SHALL have port env_out, output, 8, recovered amplitude envelope, 0..127.
REQ-010 SHALL have port peak_pulse, output, 1, one-cycle pulse on each detected envelope maximum.
REQ-011 SHALL have port period_out, output, 12, samples between the last two envelope peaks (modulation period).
REQ-012 SHALL have port period_valid, output, 1, one-cycle pulse when period_out updates.

Function
REQ-013 SHALL compute magnitude: mag = audio_in-128 if audio_in>=128, else 127-audio_in (7-bit, 0..127).
REQ-014 SHALL hold env_acc as 11-bit unsigned fixed point (7 integer, 4 fractional bits); mag_ext = mag<<4.
REQ-015 SHALL update env_acc at the clock edge ending a cycle with sample_valid=1 and en=1; it SHALL not update otherwise.
REQ-016 Attack: if mag_ext>env_acc, SHALL set env_acc += max(1, (mag_ext-env_acc)>>ATTACK_SHIFT).
REQ-017 Decay: if mag_ext<env_acc, SHALL set env_acc -= max(1, (env_acc-mag_ext)>>DECAY_SHIFT); if equal, hold.
REQ-018 SHALL drive env_out = {1'b0, env_acc[10:4]}, registered; latency 1 cycle after sample_valid.
REQ-019 SHALL generate an internal env_upd strobe one cycle after each accepted sample_valid; the peak FSM and period counter SHALL act only on env_upd.
REQ-020 Peak FSM states: IDLE, RISING, FALLING; tracks env_max and env_min (7-bit).
REQ-021 IDLE -> RISING on first env_upd; env_max := env.
REQ-022 RISING: env>env_max -> env_max := env; env+HYST<env_max -> peak detected, go FALLING, env_min := env.
REQ-023 FALLING: env<env_min -> env_min := env; env>env_min+HYST -> go RISING, env_max := env.
REQ-024 Peak detection SHALL assert peak_pulse for exactly one cycle, 2 cycles after the triggering sample_valid.
REQ-025 Period counter SHALL increment on each env_upd, saturating at 4095.
REQ-026 On a peak: if a previous peak exists since enable, SHALL load period_out with the counter value (including the current env_upd) and pulse period_valid in the same cycle as peak_pulse; the first peak SHALL set the seen-flag and pulse nothing on period_valid; in both cases the counter SHALL restart at 0.
REQ-027 A saturated period SHALL be reported as 4095.
REQ-028 sample_valid on consecutive cycles SHALL each be processed; no sample SHALL be dropped.
REQ-029 en=0 SHALL, at the next edge, clear env_acc, counter, seen-flag, env_max/env_min, return FSM to IDLE and force pulses low; period_out SHALL hold its last value; sample_valid SHALL be ignored.

Reset
REQ-030 rst SHALL asynchronously force env_out=0, peak_pulse=0, period_out=0, period_valid=0, env_acc=0, counter=0, FSM=IDLE, seen-flag=0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight env_upd; first sample after deassertion behaves as after power-up.

Structure
REQ-032 SHALL place state enum (IDLE/RISING/FALLING), ENV_ACC_W=11, ENV_FRAC=4, PERIOD_W=12 and default parameter values in package team_06_env_pkg.
REQ-033 SHALL implement the peak FSM plus period counter as sub-module team_06_env_peak_fsm (inputs env, env_upd, en; outputs peak_pulse, period_out, period_valid); magnitude and smoothing stay in the top.

Verification
REQ-034 Reset: assert rst mid-stream -> all outputs 0 immediately, FSM IDLE.
REQ-035 Attack: from 0, one sample audio_in=228 -> env_out=25 one cycle later; audio_in=27 gives identical env_out sequence; repeated samples converge monotonically to 100.
REQ-036 Decay: env_out=100 then audio_in=128 repeatedly -> env_acc drops by (env_acc>>5) or 1 per sample, monotonic to 0, never underflows.
REQ-037 Period: triangle-modulated tone with envelope period 64 samples -> first peak gives peak_pulse only; every later peak gives period_out=64 with period_valid coincident with peak_pulse.
REQ-038 Saturation: 5000 samples with no peak, then one peak after a prior peak -> period_out=4095.
REQ-039 Enable: drop en mid-stream -> env_out=0 next cycle, no pulses, period_out held; re-enable -> next peak reports no period.

Source files
------------

// File: rtl/team_06_env_pkg.sv
// Shared definitions for the envelope detector slice.
// Holds the peak-tracker state encoding, accumulator/period widths and the
// default tuning values used by team_06_env_detector.
package team_06_env_pkg;

  localparam int ENV_ACC_W        = 11;  // 7 integer + 4 fractional bits
  localparam int ENV_FRAC         = 4;
  localparam int PERIOD_W         = 12;
  localparam int ATTACK_SHIFT_DEF = 2;
  localparam int DECAY_SHIFT_DEF  = 5;
  localparam int HYST_DEF         = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RISING  = 2'd1,
    FALLING = 2'd2
  } peak_state_e;

endpackage

// File: rtl/team_06_env_peak_fsm.sv
// Envelope peak tracker and modulation-period counter.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   en            - block enable; low clears tracking state, holds period_out
//   env           - current 7-bit envelope value
//   env_upd       - strobe: env carries a freshly updated value
//   peak_pulse    - one-cycle pulse on each detected envelope maximum
//   period_out    - env_upd count between the last two peaks (saturating)
//   period_valid  - one-cycle pulse when period_out is reloaded
module team_06_env_peak_fsm
  import team_06_env_pkg::*;
#(
  parameter int HYST = HYST_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [6:0]          env,
  input  logic                env_upd,
  output logic                peak_pulse,
  output logic [PERIOD_W-1:0] period_out,
  output logic                period_valid
);

  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [8:0]          HYST_V  = 9'(HYST);

  peak_state_e         state, state_nxt;
  logic [6:0]          env_max, env_max_nxt;
  logic [6:0]          env_min, env_min_nxt;
  logic [PERIOD_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [PERIOD_W-1:0] period_nxt;
  logic                seen, seen_nxt;
  logic                peak_nxt, pv_nxt;
  logic [8:0]          env_w, max_w, min_w;

  // Widened copies so the hysteresis sums cannot wrap.
  assign env_w = {2'b00, env};
  assign max_w = {2'b00, env_max};
  assign min_w = {2'b00, env_min};

  always_comb begin
    state_nxt   = state;
    env_max_nxt = env_max;
    env_min_nxt = env_min;
    cnt_nxt     = cnt;
    seen_nxt    = seen;
    period_nxt  = period_out;
    peak_nxt    = 1'b0;
    pv_nxt      = 1'b0;
    cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    if (env_upd) begin
      cnt_nxt = cnt_inc;
      case (state)
        IDLE: begin
          state_nxt   = RISING;
          env_max_nxt = env;
        end
        RISING: begin
          if (env > env_max) begin
            env_max_nxt = env;
          end else if (env_w + HYST_V < max_w) begin
            peak_nxt    = 1'b1;
            state_nxt   = FALLING;
            env_min_nxt = env;
          end
        end
        FALLING: begin
          if (env < env_min) begin
            env_min_nxt = env;
          end else if (env_w > min_w + HYST_V) begin
            state_nxt   = RISING;
            env_max_nxt = env;
          end
        end
        default: state_nxt = IDLE;
      endcase

      // The count already includes this update; the very first peak only
      // arms the period measurement.
      if (peak_nxt) begin
        if (seen) begin
          period_nxt = cnt_inc;
          pv_nxt     = 1'b1;
        end
        seen_nxt = 1'b1;
        cnt_nxt  = '0;
      end
    end
  end

  // ---- stage 2: tracker state and pulse outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      env_max      <= '0;
      env_min      <= '0;
      cnt          <= '0;
      seen         <= 1'b0;
      period_out   <= '0;
      peak_pulse   <= 1'b0;
      period_valid <= 1'b0;
    end else if (!en) begin
      state        <= IDLE;
      env_max      <= '0;
      env_min      <= '0;
      cnt          <= '0;
      seen         <= 1'b0;
      peak_pulse   <= 1'b0;
      period_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      env_max      <= env_max_nxt;
      env_min      <= env_min_nxt;
      cnt          <= cnt_nxt;
      seen         <= seen_nxt;
      period_out   <= period_nxt;
      peak_pulse   <= peak_nxt;
      period_valid <= pv_nxt;
    end
  end

endmodule

// File: rtl/team_06_env_detector.sv
// Audio amplitude-envelope detector with peak and modulation-period output.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   en            - block enable; low clears the envelope and peak tracking
//   sample_valid  - one-cycle strobe qualifying audio_in
//   audio_in      - offset-binary sample, 128 = silence
//   env_out       - smoothed envelope 0..127, valid one cycle after a sample
//   peak_pulse    - one-cycle pulse per envelope maximum (2 cycles after sample)
//   period_out    - samples between the last two peaks, saturating at 4095
//   period_valid  - pulses with peak_pulse whenever period_out reloads
module team_06_env_detector
  import team_06_env_pkg::*;
#(
  parameter int ATTACK_SHIFT = ATTACK_SHIFT_DEF,
  parameter int DECAY_SHIFT  = DECAY_SHIFT_DEF,
  parameter int HYST         = HYST_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sample_valid,
  input  logic [7:0]          audio_in,
  output logic [7:0]          env_out,
  output logic                peak_pulse,
  output logic [PERIOD_W-1:0] period_out,
  output logic                period_valid
);

  // Offset-binary magnitude: above mid-scale the low bits are the distance
  // from 128; below it the inverted low bits equal 127 - sample.
  function automatic logic [6:0] magnitude(input logic [7:0] s);
    return s[7] ? s[6:0] : ~s[6:0];
  endfunction

  // Asymmetric one-pole smoother; step is at least one LSB and never
  // exceeds the gap, so the accumulator cannot overshoot or wrap.
  function automatic logic [ENV_ACC_W-1:0] smooth(input logic [ENV_ACC_W-1:0] acc,
                                                  input logic [ENV_ACC_W-1:0] tgt);
    logic [ENV_ACC_W-1:0] diff;
    logic [ENV_ACC_W-1:0] step;
    if (tgt > acc) begin
      diff = tgt - acc;
      step = diff >> ATTACK_SHIFT;
      if (step == '0) step = ENV_ACC_W'(1);
      return acc + step;
    end else if (tgt < acc) begin
      diff = acc - tgt;
      step = diff >> DECAY_SHIFT;
      if (step == '0) step = ENV_ACC_W'(1);
      return acc - step;
    end
    return acc;
  endfunction

  logic [ENV_ACC_W-1:0] mag_ext_p0;
  logic [ENV_ACC_W-1:0] env_acc_p1;
  logic                 vld_p1;

  assign mag_ext_p0 = {magnitude(audio_in), {ENV_FRAC{1'b0}}};

  // ---- stage 1: envelope accumulator and update strobe ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      env_acc_p1 <= '0;
      vld_p1     <= 1'b0;
    end else if (!en) begin
      env_acc_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= sample_valid;
      if (sample_valid) env_acc_p1 <= smooth(env_acc_p1, mag_ext_p0);
    end
  end

  assign env_out = {1'b0, env_acc_p1[ENV_ACC_W-1:ENV_FRAC]};

  // ---- stage 2: peak tracking on the updated envelope ----
  team_06_env_peak_fsm #(
    .HYST(HYST)
  ) u_peak (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .env          (env_out[6:0]),
    .env_upd      (vld_p1),
    .peak_pulse   (peak_pulse),
    .period_out   (period_out),
    .period_valid (period_valid)
  );

endmodule
